// File: rtl/ir_command_receiver_pkg.sv
// Shared definitions for the IR command receiver.
//
// Contents:
//   - ir_state_t    : receiver FSM state encoding (exposed on the debug port)
//   - command field : bit positions of the angle and distance fields
//   - T_*           : default pulse timing in 25 MHz clock cycles
//   - counter widths used by the receiver datapath
package ir_command_receiver_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_GAP   = 3'd2,
        S_BIT   = 3'd3,
        S_DONE  = 3'd4
    } ir_state_t;

    // Command layout: angle in 15-degree steps, distance in 4-inch steps.
    localparam int CMD_W     = 12;
    localparam int ANGLE_MSB = 11;
    localparam int ANGLE_LSB = 7;
    localparam int DIST_MSB  = 6;
    localparam int DIST_LSB  = 0;

    // Default pulse timing at 25 MHz.
    localparam int T_START_MIN     = 45000;    // 1.8 ms
    localparam int T_START_MAX     = 75000;    // 3.0 ms, also the per-mark timeout
    localparam int T_ONE_MIN       = 22500;    // 0.9 ms
    localparam int T_ZERO_MIN      = 7500;     // 0.3 ms
    localparam int T_GAP_MAX       = 30000;    // 1.2 ms
    localparam int T_REPEAT_WINDOW = 2500000;  // 100 ms

    // Width counter and the one-bit-wider view used for comparisons.
    localparam int WIDTH_W   = 18;
    localparam int ELAPSED_W = WIDTH_W + 1;
    localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/ir_command_receiver_edge_sync.sv
// ir_edge_sync: input conditioning for a raw demodulated IR line.
//
// Two-flop synchronizer, polarity normalisation (level=1 means carrier
// present, i.e. "mark") and single-cycle rise/fall strobes derived by
// comparing the normalised level with its registered previous value.
// Also used by the base-station debug receiver.
//
// Parameters:
//   ACTIVE_HIGH  0: raw line is pulled low during a mark; 1: high during a mark
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-high; both synchronizer flops load the
//               inactive line level so no spurious edge follows reset
//   raw    in   asynchronous IR line
//   level  out  synchronized, normalised line (1 = mark)
//   rise   out  one-cycle strobe at the start of a mark
//   fall   out  one-cycle strobe at the end of a mark
module ir_edge_sync
    import ir_command_receiver_pkg::*;
#(
    parameter int ACTIVE_HIGH = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic IDLE_LEVEL = (ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= IDLE_LEVEL;
            sync2 <= IDLE_LEVEL;
            prev  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= level;
        end
    end

    assign level = (ACTIVE_HIGH != 0) ? sync2 : ~sync2;
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/ir_command_receiver.sv
// ir_command_receiver: SIRC-style IR frame decoder feeding the rover motor
// sequencer.
//
// A frame is one start mark followed by 12 pulse-width-coded bits, LSB
// first. Each bit is a space followed by a mark whose length selects 0 or 1.
// A decoded command is parked in a one-deep "pending" slot (latest frame
// wins) and handed over as a one-cycle command_ready strobe only while the
// sequencer reports idle.
//
// Optional feature (macro IR_REPEAT_SUPPRESS_EN): drop a frame that repeats
// the last accepted command within REPEAT_WINDOW cycles of the previous
// completed frame, so a held remote button issues a single command.
//
// Ports:
//   clock            in   25 MHz system clock
//   reset            in   synchronous, active-high
//   ir_in            in   raw demodulated IR, asynchronous
//   downstream_idle  in   sequencer can accept a command
//   command_ready    out  one-cycle strobe, command valid this cycle
//   command[11:0]    out  decoded command, held until the next strobe
//   frame_error      out  one-cycle strobe on a malformed/aborted frame
//   state[2:0]       out  FSM state for debug
//
// Handshake: command_ready is a pure strobe with no back-pressure. It is only
// raised in a cycle that follows a cycle where downstream_idle was high with
// a command pending; command is updated in that same cycle and then held.
module ir_command_receiver
    import ir_command_receiver_pkg::*;
#(
    parameter int IR_ACTIVE_HIGH = 0,
    parameter int START_MIN      = T_START_MIN,
    parameter int START_MAX      = T_START_MAX,
    parameter int ONE_MIN        = T_ONE_MIN,
    parameter int ZERO_MIN       = T_ZERO_MIN,
    parameter int GAP_MAX        = T_GAP_MAX
`ifdef IR_REPEAT_SUPPRESS_EN
    ,
    parameter int REPEAT_WINDOW  = T_REPEAT_WINDOW
`endif
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ir_in,
    input  logic             downstream_idle,
    output logic             command_ready,
    output logic [CMD_W-1:0] command,
    output logic             frame_error,
    output logic [2:0]       state
);

    localparam logic [WIDTH_W-1:0]   WIDTH_SAT   = WIDTH_W'(START_MAX + 1);
    localparam logic [ELAPSED_W-1:0] START_MIN_E = ELAPSED_W'(START_MIN);
    localparam logic [ELAPSED_W-1:0] START_MAX_E = ELAPSED_W'(START_MAX);
    localparam logic [ELAPSED_W-1:0] ONE_MIN_E   = ELAPSED_W'(ONE_MIN);
    localparam logic [ELAPSED_W-1:0] ZERO_MIN_E  = ELAPSED_W'(ZERO_MIN);
    localparam logic [ELAPSED_W-1:0] GAP_MAX_E   = ELAPSED_W'(GAP_MAX);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(CMD_W - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic mark;
    logic rise;
    logic fall;

    ir_edge_sync #(
        .ACTIVE_HIGH(IR_ACTIVE_HIGH)
    ) u_edge_sync (
        .clock(clock),
        .reset(reset),
        .raw  (ir_in),
        .level(mark),
        .rise (rise),
        .fall (fall)
    );

    // ------------------------------------------------------------------
    // Width counter
    // ------------------------------------------------------------------
    // The counter is cleared by the edge strobe, so it lags the line by one
    // cycle. elapsed = width + 1 is the number of cycles the previous level
    // has lasted; in an edge cycle it is exactly the length of the mark or
    // space that just ended, which is what the thresholds are written for.
    logic [WIDTH_W-1:0]   width;
    logic [ELAPSED_W-1:0] elapsed;

    assign elapsed = {1'b0, width} + ELAPSED_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            width <= '0;
        end else if (rise || fall) begin
            width <= '0;
        end else if (width != WIDTH_SAT) begin
            width <= width + WIDTH_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    ir_state_t state_q;
    ir_state_t state_next;

    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [CMD_W-1:0]     shift;

    logic err_next;
    logic bit_clr;
    logic bit_inc;
    logic shift_wr;
    logic bit_val;
    logic done;

    assign bit_val = (elapsed >= ONE_MIN_E);

    always_comb begin
        state_next = state_q;
        err_next   = 1'b0;
        bit_clr    = 1'b0;
        bit_inc    = 1'b0;
        shift_wr   = 1'b0;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_next = S_START;
                end
            end

            S_START: begin
                if (fall) begin
                    if ((elapsed >= START_MIN_E) && (elapsed <= START_MAX_E)) begin
                        state_next = S_GAP;
                        bit_clr    = 1'b1;
                    end else begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end
                end else if (mark && (elapsed > START_MAX_E)) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end
            end

            S_GAP: begin
                // Timeout takes priority so a space of GAP_MAX+1 cycles is
                // rejected even when the next mark starts in that cycle.
                if (elapsed > GAP_MAX_E) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else if (rise) begin
                    state_next = S_BIT;
                end
            end

            S_BIT: begin
                if (fall) begin
                    if ((elapsed < ZERO_MIN_E) || (elapsed >= START_MIN_E)) begin
                        err_next   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        shift_wr = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            state_next = S_DONE;
                        end else begin
                            bit_inc    = 1'b1;
                            state_next = S_GAP;
                        end
                    end
                end else if (mark && (elapsed > START_MAX_E)) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end
            end

            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Frame acceptance
    // ------------------------------------------------------------------
    logic accept;

`ifdef IR_REPEAT_SUPPRESS_EN
    localparam int              REP_W   = $clog2(REPEAT_WINDOW + 1);
    localparam logic [REP_W-1:0] REP_SAT = REP_W'(REPEAT_WINDOW);

    logic [CMD_W-1:0] last_cmd;
    logic [REP_W-1:0] since;

    // A repeat restarts the window as well, so a held button stays quiet.
    assign accept = done && !((shift == last_cmd) && (since < REP_SAT));

    always_ff @(posedge clock) begin
        if (reset) begin
            last_cmd <= '0;
            since    <= REP_SAT;
        end else begin
            if (done) begin
                since <= '0;
            end else if (since != REP_SAT) begin
                since <= since + REP_W'(1);
            end
            if (accept) begin
                last_cmd <= shift;
            end
        end
    end
`else
    assign accept = done;
`endif

    // ------------------------------------------------------------------
    // Datapath and sequencer handshake
    // ------------------------------------------------------------------
    logic             pending;
    logic [CMD_W-1:0] pending_cmd;
    logic             issue;

    // Issue samples the slot as it was at the start of the cycle; a frame
    // finishing in the same cycle refills the slot for a later hand-over.
    assign issue = pending && downstream_idle;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            pending       <= 1'b0;
            pending_cmd   <= '0;
            command       <= '0;
            command_ready <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state_q     <= state_next;
            frame_error <= err_next;

            if (bit_clr) begin
                bit_cnt <= '0;
                shift   <= '0;
            end else if (bit_inc) begin
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end

            if (shift_wr) begin
                shift[bit_cnt] <= bit_val;
            end

            if (accept) begin
                pending     <= 1'b1;
                pending_cmd <= shift;
            end else if (issue) begin
                pending <= 1'b0;
            end

            command_ready <= issue;
            if (issue) begin
                command[ANGLE_MSB:ANGLE_LSB] <= pending_cmd[ANGLE_MSB:ANGLE_LSB];
                command[DIST_MSB:DIST_LSB]   <= pending_cmd[DIST_MSB:DIST_LSB];
            end
        end
    end

    assign state = state_q;

endmodule
